// File: rtl/mips_immediate_extend_pipe_if.sv
// Request/response bundle for the registered immediate extender.
// The master side issues immediates and consumes results; the slave side is the extender.
interface mips_immediate_extend_pipe_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_imm;
    logic [1:0]           in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [1:0]           out_mode;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );
endinterface

// File: rtl/mips_immediate_extend_pipe.sv
// Registered sign/zero/upper/branch immediate extender with a one-entry skid buffer,
// so a stalled execute stage never causes an accepted immediate to be lost.
module mips_immediate_extend_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input logic                     clk,
    input logic                     rst,
    mips_immediate_extend_pipe_if.slave bus
);
    localparam int EXT = OUT_WIDTH - IN_WIDTH;

    generate
        if (OUT_WIDTH < IN_WIDTH + 2) begin : g_width_check
            $error("mips_immediate_extend_pipe: OUT_WIDTH must be at least IN_WIDTH + 2");
        end
    endgenerate

    logic [OUT_WIDTH-1:0] sext_w;
    logic [OUT_WIDTH-1:0] ext_w;
    logic                 in_fire_w;

    logic                 out_valid_q,  out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q,   out_data_d;
    logic [1:0]           out_mode_q,   out_mode_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [OUT_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic [1:0]           skid_mode_q,  skid_mode_d;
    logic                 in_ready_q,   in_ready_d;

    always_comb begin
        sext_w = {{EXT{bus.in_imm[IN_WIDTH-1]}}, bus.in_imm};
        case (bus.in_mode)
            2'b00:   ext_w = sext_w;
            2'b01:   ext_w = {{EXT{1'b0}}, bus.in_imm};
            2'b10:   ext_w = {bus.in_imm, {EXT{1'b0}}};
            default: ext_w = {sext_w[OUT_WIDTH-3:0], 2'b00};
        endcase
    end

    assign in_fire_w = bus.in_valid && in_ready_q;

    // The skid always drains before new input; in_ready is low whenever the skid holds data.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_mode_d   = out_mode_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_mode_d  = skid_mode_q;
        if (!out_valid_q || bus.out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_mode_d   = skid_mode_q;
                skid_valid_d = 1'b0;
            end else if (in_fire_w) begin
                out_valid_d = 1'b1;
                out_data_d  = ext_w;
                out_mode_d  = bus.in_mode;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire_w) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ext_w;
            skid_mode_d  = bus.in_mode;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_mode_q   <= 2'b00;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_mode_q  <= 2'b00;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_mode_q   <= out_mode_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_mode_q  <= skid_mode_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_mode  = out_mode_q;
endmodule

// File: tb/tb_mips_immediate_extend_pipe.sv
// Scoreboard bench for mips_immediate_extend_pipe: default 16->32 instance plus an 8->16 variant.
module tb_mips_immediate_extend_pipe;
    logic clk;
    logic rst;
    int   testCount;
    int   failCount;
    int   cycleCount;
    logic randomReady;

    logic [33:0] sb[$];
    logic [17:0] sbNarrow[$];
    int          popCycles[$];

    mips_immediate_extend_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) bus ();
    mips_immediate_extend_pipe_if #(.IN_WIDTH(8),  .OUT_WIDTH(16)) busNarrow ();

    mips_immediate_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mips_immediate_extend_pipe #(.IN_WIDTH(8), .OUT_WIDTH(16)) dutNarrow (
        .clk (clk),
        .rst (rst),
        .bus (busNarrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    always @(posedge clk) begin
        if (randomReady) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference extension for the 16->32 instance, written with signed arithmetic.
    function automatic logic [33:0] refExtend(input logic [15:0] imm, input logic [1:0] mode);
        int s;
        logic [31:0] d;
        s = int'($signed(imm));
        case (mode)
            2'd0:    d = 32'(s);
            2'd1:    d = 32'(imm);
            2'd2:    d = 32'(imm) * 32'd65536;
            default: d = 32'(s * 4);
        endcase
        return {mode, d};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", {30'd0, bus.out_mode, bus.out_data}, 64'hdead);
            end else begin
                checkOutput("scoreboard", {30'd0, bus.out_mode, bus.out_data}, {30'd0, sb.pop_front()});
                popCycles.push_back(cycleCount);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && busNarrow.out_valid && busNarrow.out_ready) begin
            if (sbNarrow.size() == 0) begin
                checkOutput("unexpected_narrow", {46'd0, busNarrow.out_mode, busNarrow.out_data}, 64'hdead);
            end else begin
                checkOutput("scoreboard_narrow", {46'd0, busNarrow.out_mode, busNarrow.out_data},
                            {46'd0, sbNarrow.pop_front()});
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepts the request.
    task automatic applyStimulus(input logic [15:0] imm, input logic [1:0] mode,
                                 input logic [31:0] expData, output int waitCycles);
        bit accepted;
        accepted = 0;
        waitCycles = 0;
        bus.in_valid = 1'b1;
        bus.in_imm   = imm;
        bus.in_mode  = mode;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back({mode, expData});
                accepted = 1;
            end else begin
                waitCycles++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic applyStimulusNarrow(input logic [7:0] imm, input logic [1:0] mode, input logic [15:0] expData);
        bit accepted;
        accepted = 0;
        busNarrow.in_valid = 1'b1;
        busNarrow.in_imm   = imm;
        busNarrow.in_mode  = mode;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (busNarrow.in_ready) begin
                sbNarrow.push_back({mode, expData});
                accepted = 1;
            end
            @(posedge clk);
            #1;
        end
        busNarrow.in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout_narrow", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && sbNarrow.size() == 0) done = 1;
        end
        if (!done) checkOutput("drain_timeout", 64'(sb.size() + sbNarrow.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int p0;
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [33:0] r;

        testCount   = 0;
        failCount   = 0;
        cycleCount  = 0;
        randomReady = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_imm   = '0;
        bus.in_mode  = 2'b00;
        bus.out_ready = 1'b1;
        busNarrow.in_valid  = 1'b0;
        busNarrow.in_imm    = '0;
        busNarrow.in_mode   = 2'b00;
        busNarrow.out_ready = 1'b1;

        #23 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_out_data",  64'(bus.out_data),  64'd0);
        checkOutput("reset_out_mode",  64'(bus.out_mode),  64'd0);
        checkOutput("reset_in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1;

        $display("[TB] mode sweep");
        applyStimulus(16'h8000, 2'b00, 32'hffff8000, w);
        applyStimulus(16'h7fff, 2'b00, 32'h00007fff, w);
        applyStimulus(16'hffff, 2'b01, 32'h0000ffff, w);
        applyStimulus(16'h1234, 2'b10, 32'h12340000, w);
        applyStimulus(16'hfffe, 2'b11, 32'hfffffff8, w);
        applyStimulus(16'h0001, 2'b11, 32'h00000004, w);
        drain();

        $display("[TB] back-to-back stream");
        p0 = popCycles.size();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(16'(i), 2'b00, 32'(i), w);
            checkOutput("stream_in_ready_wait", 64'(w), 64'd0);
        end
        drain();
        checkOutput("stream_pop_count", 64'(popCycles.size() - p0), 64'd8);
        if (popCycles.size() >= p0 + 8)
            checkOutput("stream_consecutive", 64'(popCycles[p0 + 7] - popCycles[p0]), 64'd7);

        $display("[TB] back-pressure");
        bus.out_ready = 1'b0;
        applyStimulus(16'hfffe, 2'b00, 32'hfffffffe, w);
        applyStimulus(16'h0001, 2'b00, 32'h00000001, w);
        bus.in_valid = 1'b1;
        bus.in_imm   = 16'h0002;
        bus.in_mode  = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready_low", 64'(bus.in_ready),  64'd0);
            checkOutput("bp_hold_valid",   64'(bus.out_valid), 64'd1);
            checkOutput("bp_hold_data",    64'(bus.out_data),  64'hfffffffe);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        applyStimulus(16'h0002, 2'b00, 32'h00000002, w);
        drain();

        $display("[TB] narrow parameter variant");
        applyStimulusNarrow(8'h80, 2'b00, 16'hff80);
        applyStimulusNarrow(8'hab, 2'b10, 16'hab00);
        applyStimulusNarrow(8'h40, 2'b11, 16'h0100);
        drain();

        $display("[TB] reset mid-operation");
        bus.out_ready = 1'b0;
        applyStimulus(16'h0010, 2'b00, 32'h00000010, w);
        applyStimulus(16'h0011, 2'b00, 32'h00000011, w);
        @(negedge clk);
        checkOutput("pre_reset_in_ready", 64'(bus.in_ready), 64'd0);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("async_reset_out_data",  64'(bus.out_data),  64'd0);
        checkOutput("async_reset_in_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("post_reset_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        applyStimulus(16'h0005, 2'b01, 32'h00000005, w);
        drain();

        $display("[TB] random cross-check");
        randomReady = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                @(posedge clk);
                #1;
            end
            imm  = 16'($urandom);
            mode = 2'($urandom_range(0, 3));
            r = refExtend(imm, mode);
            applyStimulus(imm, mode, r[31:0], w);
        end
        randomReady = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        drain();
        checkOutput("final_scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/mips_immediate_extend_pipe.md
# mips_immediate_extend_pipe

Parametrised, registered successor to the combinational `mips_sign_extension` unit. It accepts an immediate field plus an extension mode over a valid/ready handshake. It produces the sign-, zero-, upper- or branch-extended word one cycle later through an output register backed by a one-entry skid buffer. It sits between the decode stage and the ALU/branch-target operand muxes, so back-pressure from a stalled execute stage never drops an immediate.

## Interface
Parameters:
- `IN_WIDTH`, default 16: width of the immediate field.
- `OUT_WIDTH`, default 32: width of the extended result.
  - Must satisfy `OUT_WIDTH >= IN_WIDTH + 2`.
  - Elaboration fails otherwise.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  reset; asynchronous and active-high.
- `in_valid`  input  1  `in_imm`/`in_mode` carry a request.
- `in_ready`  output  1  block can accept a request this cycle.
- `in_imm`  input  IN_WIDTH  immediate field.
- `in_mode`  input  2  extension mode:
  - 00 = sign-extend
  - 01 = zero-extend
  - 10 = upper (LUI)
  - 11 = branch (sign-extend, shift left 2)
- `out_valid`  output  1  `out_data` holds a result.
- `out_ready`  input  1  consumer takes the result this cycle.
- `out_data`  output  OUT_WIDTH  extended result.
- `out_mode`  output  2  mode the current `out_data` was produced with.

## Operation
- Input transfer occurs when `in_valid && in_ready` at a rising edge. Output transfer occurs when `out_valid && out_ready`.
- Arithmetic, with `E = OUT_WIDTH - IN_WIDTH`:
  - Mode 00: `{E copies of in_imm[IN_WIDTH-1], in_imm}`.
  - Mode 01: `{E zeros, in_imm}`.
  - Mode 10: `in_imm` placed in the top IN_WIDTH bits, low E bits zero.
  - Mode 11: mode-00 result shifted left 2, truncated to OUT_WIDTH. The sign is preserved because `E >= 2`.
- The result is computed combinationally from the input and captured with `in_mode` into the output stage or the skid entry. Nothing is recomputed later.
- Storage: output register (`out_valid`, `out_data`, `out_mode`) plus one skid entry (`skid_valid`, data, mode).
- `in_ready` is a registered signal equal to `!skid_valid`. It has no combinational path from `out_ready`.
- Per-edge update rules, in priority order:
  1. Output empty or being taken (`!out_valid || out_ready`):
     - If skid valid: output loads the skid entry and the skid clears.
     - Else if an input transfer occurs: output loads the new result.
     - Else: `out_valid` goes to 0.
  2. Output stalled (`out_valid && !out_ready`): the output holds. An input transfer, if any, loads the skid entry.
- While skid valid, `in_ready = 0`, so no input is accepted on the edge the skid drains. `in_ready` returns to 1 on the following cycle.
- Reset (asserted at any time, including mid-transfer):
  - `out_valid = 0`, `out_data = 0`, `out_mode = 00`.
  - Skid cleared; `in_ready = 1`.
  - Any held or pending request is discarded.
- No request is ever duplicated, dropped or reordered outside reset.

## Timing
- Latency: 1 cycle. A request accepted at edge N is on `out_data` with `out_valid = 1` from edge N to edge N+1, provided the output was free.
- Throughput: 1 result per cycle while `out_ready` stays high.
- `out_data`/`out_mode` are stable from the edge `out_valid` rises until the edge where the output transfer completes.
- On the first stall cycle, one extra request is absorbed into the skid. `in_ready` falls on the next edge.
- After a stall ends, the skid entry appears on the output one edge later. `in_ready` rises on that same edge.
- Simultaneous output and input transfer with an empty skid: the output replaces its contents with the new result and no bubble is inserted.
- Reset deassertion: `in_ready = 1` in the first cycle after reset. The first request can be accepted on the next edge.

## Test plan
- Mode sweep, defaults, `out_ready = 1`, checked one cycle after each request:
  - mode 00, `in_imm = 16'h8000` -> `32'hffff8000`
  - mode 00, `16'h7fff` -> `32'h00007fff`
  - mode 01, `16'hffff` -> `32'h0000ffff`
  - mode 10, `16'h1234` -> `32'h12340000`
  - mode 11, `16'hfffe` -> `32'hfffffff8`
  - mode 11, `16'h0001` -> `32'h00000004`
- Stream of 8 mode-00 requests `16'h0000..16'h0007` back-to-back with `out_ready = 1`:
  - `in_ready` stays 1 throughout.
  - Results appear on 8 consecutive cycles, in order.
- Back-pressure: `out_ready = 0` while sending A = `16'hfffe`, B = `16'h0001`, C = `16'h0002` (mode 00):
  - A is held on the output.
  - B is accepted into the skid.
  - `in_ready` falls; C is not accepted.
  - Releasing `out_ready` yields A, then B, then C, with no loss and no duplicate.
- Parameter variant `IN_WIDTH = 8`, `OUT_WIDTH = 16`:
  - mode 00, `8'h80` -> `16'hff80`
  - mode 10, `8'hab` -> `16'hab00`
  - mode 11, `8'h40` -> `16'h0100`
- Reset mid-operation with output and skid both full:
  - Asserting `rst` asynchronously (between edges) drops `out_valid` to 0 immediately, sets `out_data = 0` and raises `in_ready` to 1.
  - After release, the next request `16'h0005` (mode 01) produces exactly `32'h00000005`.
- Randomised cross-check of 1000 requests with random `in_valid`/`out_ready`: every output equals the reference extension of the matching input, in order.
